// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts a byte plus odd parity out on device clock edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       edge_reg, edge_next;
    logic [8:0]       shift_reg, shift_next;
    logic             clk_oe_reg, clk_oe_next;
    logic             data_oe_reg, data_oe_next;
    logic             done_reg, done_next;
    logic             nack_reg, nack_next;
    logic             timeout_reg, timeout_next;

    // Index 0 carries the PS/2 clock, index 1 the PS/2 data line.
    logic [1:0] pin_in;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic       clk_prev_reg;
    logic       fall;

    assign pin_in = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= pin_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= sync2_reg[0];
        end
    end

    assign fall = clk_prev_reg & ~sync2_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            edge_reg    <= '0;
            shift_reg   <= '0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            done_reg    <= 1'b0;
            nack_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            edge_reg    <= edge_next;
            shift_reg   <= shift_next;
            clk_oe_reg  <= clk_oe_next;
            data_oe_reg <= data_oe_next;
            done_reg    <= done_next;
            nack_reg    <= nack_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        edge_next    = edge_reg;
        shift_next   = shift_reg;
        clk_oe_next  = clk_oe_reg;
        data_oe_next = data_oe_reg;
        done_next    = 1'b0;
        nack_next    = 1'b0;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shift_next   = {~^tx_data, tx_data};
                    edge_next    = '0;
                    cnt_next     = '0;
                    clk_oe_next  = 1'b1;
                    data_oe_next = (INHIBIT_CYCLES == 1);
                    state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                // The start bit is asserted on the last inhibit cycle so the
                // device sees data low the moment the clock is released.
                if (cnt_reg == INH_LAST) begin
                    clk_oe_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = START;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == INH_DATA) begin
                        data_oe_next = 1'b1;
                    end
                end
            end

            START, SHIFT, ACK, WAIT_IDLE: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (fall) begin
                    cnt_next = '0;
                    if (state_reg == ACK) begin
                        if (sync2_reg[1]) begin
                            nack_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = WAIT_IDLE;
                        end
                    end else if (state_reg != WAIT_IDLE) begin
                        edge_next = edge_reg + 4'd1;
                        if (edge_reg == 4'd9) begin
                            data_oe_next = 1'b0;
                            state_next   = ACK;
                        end else begin
                            data_oe_next = ~shift_reg[0];
                            shift_next   = {1'b0, shift_reg[8:1]};
                            state_next   = SHIFT;
                        end
                    end
                end else if (cnt_reg == TMO_LAST) begin
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else if (state_reg == WAIT_IDLE && sync2_reg[0] && sync2_reg[1]) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next   = IDLE;
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
            end
        endcase
    end

    // Ready is held off during the completion pulse so a new byte cannot
    // be accepted in the same cycle the previous one reports its outcome.
    assign tx_ready    = (state_reg == IDLE) && !(done_reg || nack_reg || timeout_reg);
    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign done        = done_reg;
    assign nack        = nack_reg;
    assign timeout     = timeout_reg;

endmodule
